// File: rtl/stereo_frame_aligner_if.sv
// ---------------------------------------------------------------------------
// stereo_frame_aligner_if
// Bundles every non-clock/reset signal of stereo_frame_aligner.
//   c0_* / c1_*  : per-camera head-of-buffer stream (valid, pixel, sof) and
//                  the pop strobe back to each buffer (ready).
//   pair_*       : registered paired output with valid/ready handshake.
//   aligned_o, resync_count_o, c0/c1_drop_count_o : status.
// Modports:
//   master : the environment (camera buffers + downstream consumer).
//   slave  : the aligner itself.
// ---------------------------------------------------------------------------
interface stereo_frame_aligner_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                     c0_valid_i;
    logic [PIXEL_WIDTH-1:0]   c0_pixel_i;
    logic                     c0_sof_i;
    logic                     c0_ready_o;
    logic                     c1_valid_i;
    logic [PIXEL_WIDTH-1:0]   c1_pixel_i;
    logic                     c1_sof_i;
    logic                     c1_ready_o;
    logic                     pair_valid_o;
    logic [2*PIXEL_WIDTH-1:0] pair_pixels_o;
    logic                     pair_sof_o;
    logic                     pair_eol_o;
    logic                     pair_eof_o;
    logic                     pair_ready_i;
    logic                     aligned_o;
    logic [15:0]              resync_count_o;
    logic [15:0]              c0_drop_count_o;
    logic [15:0]              c1_drop_count_o;

    modport master (
        output c0_valid_i, c0_pixel_i, c0_sof_i,
        output c1_valid_i, c1_pixel_i, c1_sof_i,
        output pair_ready_i,
        input  c0_ready_o, c1_ready_o,
        input  pair_valid_o, pair_pixels_o, pair_sof_o, pair_eol_o, pair_eof_o,
        input  aligned_o, resync_count_o, c0_drop_count_o, c1_drop_count_o
    );

    modport slave (
        input  c0_valid_i, c0_pixel_i, c0_sof_i,
        input  c1_valid_i, c1_pixel_i, c1_sof_i,
        input  pair_ready_i,
        output c0_ready_o, c1_ready_o,
        output pair_valid_o, pair_pixels_o, pair_sof_o, pair_eol_o, pair_eof_o,
        output aligned_o, resync_count_o, c0_drop_count_o, c1_drop_count_o
    );
endinterface

// File: rtl/stereo_frame_aligner.sv
// ---------------------------------------------------------------------------
// stereo_frame_aligner
// Pops two camera pixel streams in lockstep and emits {c1,c0} pixel pairs
// with sof/eol/eof framing. Hunts for a common start-of-frame, streams one
// frame, and drops back to hunting on eof or on any detected misalignment.
// Ports:
//   clk_i   : system clock
//   rst_n_i : asynchronous active-low reset
//   bus     : stereo_frame_aligner_if.slave (camera inputs, pops, paired
//             output handshake, status counters)
// Optional feature macro: STEREO_ALIGN_STATS_EN
//   defined   -> c0/c1_drop_count_o count pixels discarded while hunting
//   undefined -> both drop counters are tied to 0
// ---------------------------------------------------------------------------
module stereo_frame_aligner #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIXEL_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    stereo_frame_aligner_if.slave bus
);
    localparam int CW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

    typedef enum logic {S_HUNT = 1'b0, S_STREAM = 1'b1} state_t;

    state_t                   r_state, w_state_nxt;
    logic [CW-1:0]            r_col, w_col_nxt;
    logic [RW-1:0]            r_row, w_row_nxt;
    logic                     r_pair_valid;
    logic [2*PIXEL_WIDTH-1:0] r_pair_pixels;
    logic                     r_pair_sof, r_pair_eol, r_pair_eof;
    logic [15:0]              r_resync;

    logic w_slot_free, w_at_origin, w_last_col, w_last_row, w_misalign;
    logic w_fire, w_resync_inc, w_c0_ready, w_c1_ready;
    logic w_c0_head_sof, w_c1_head_sof, w_c0_head_px, w_c1_head_px;

    assign w_slot_free   = !r_pair_valid || bus.pair_ready_i;
    assign w_at_origin   = (r_col == '0) && (r_row == '0);
    assign w_last_col    = (r_col == COL_LAST);
    assign w_last_row    = (r_row == ROW_LAST);
    assign w_c0_head_sof = bus.c0_valid_i &&  bus.c0_sof_i;
    assign w_c1_head_sof = bus.c1_valid_i &&  bus.c1_sof_i;
    assign w_c0_head_px  = bus.c0_valid_i && !bus.c0_sof_i;
    assign w_c1_head_px  = bus.c1_valid_i && !bus.c1_sof_i;

    // At the frame origin both heads must carry sof; anywhere else a sof
    // head means one camera lost or gained pixels.
    assign w_misalign = w_at_origin ? (w_c0_head_px  || w_c1_head_px)
                                    : (w_c0_head_sof || w_c1_head_sof);

    always_comb begin
        w_state_nxt  = r_state;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_c0_ready   = 1'b0;
        w_c1_ready   = 1'b0;
        w_fire       = 1'b0;
        w_resync_inc = 1'b0;
        case (r_state)
            S_HUNT: begin
                // Discard non-sof heads, hold sof heads. Discards also wait
                // for a stalled output word so nothing is popped during a stall.
                w_c0_ready = w_slot_free && w_c0_head_px;
                w_c1_ready = w_slot_free && w_c1_head_px;
                if (w_c0_head_sof && w_c1_head_sof) begin
                    w_state_nxt = S_STREAM;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end
            end
            S_STREAM: begin
                if (w_misalign) begin
                    w_resync_inc = 1'b1;
                    w_state_nxt  = S_HUNT;
                    w_col_nxt    = '0;
                    w_row_nxt    = '0;
                end else if (bus.c0_valid_i && bus.c1_valid_i && w_slot_free) begin
                    w_fire     = 1'b1;
                    w_c0_ready = 1'b1;
                    w_c1_ready = 1'b1;
                    if (w_last_col) begin
                        w_col_nxt = '0;
                        if (w_last_row) begin
                            w_row_nxt   = '0;
                            w_state_nxt = S_HUNT;
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                        end
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
                w_col_nxt   = '0;
                w_row_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_HUNT;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Output word: loads on fire, otherwise holds until accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pair_valid  <= 1'b0;
            r_pair_pixels <= '0;
            r_pair_sof    <= 1'b0;
            r_pair_eol    <= 1'b0;
            r_pair_eof    <= 1'b0;
        end else if (w_fire) begin
            r_pair_valid  <= 1'b1;
            r_pair_pixels <= {bus.c1_pixel_i, bus.c0_pixel_i};
            r_pair_sof    <= w_at_origin;
            r_pair_eol    <= w_last_col;
            r_pair_eof    <= w_last_col && w_last_row;
        end else if (bus.pair_ready_i) begin
            r_pair_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_resync <= '0;
        end else if (w_resync_inc && (r_resync != 16'hFFFF)) begin
            r_resync <= r_resync + 16'd1;
        end
    end

`ifdef STEREO_ALIGN_STATS_EN
    logic [15:0] r_c0_drop, r_c1_drop;
    logic        w_c0_drop, w_c1_drop;

    // Pops while hunting are always discards.
    assign w_c0_drop = (r_state == S_HUNT) && bus.c0_valid_i && w_c0_ready;
    assign w_c1_drop = (r_state == S_HUNT) && bus.c1_valid_i && w_c1_ready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_c0_drop <= '0;
            r_c1_drop <= '0;
        end else begin
            if (w_c0_drop && (r_c0_drop != 16'hFFFF)) r_c0_drop <= r_c0_drop + 16'd1;
            if (w_c1_drop && (r_c1_drop != 16'hFFFF)) r_c1_drop <= r_c1_drop + 16'd1;
        end
    end

    assign bus.c0_drop_count_o = r_c0_drop;
    assign bus.c1_drop_count_o = r_c1_drop;
`else
    assign bus.c0_drop_count_o = 16'd0;
    assign bus.c1_drop_count_o = 16'd0;
`endif

    assign bus.c0_ready_o     = w_c0_ready;
    assign bus.c1_ready_o     = w_c1_ready;
    assign bus.pair_valid_o   = r_pair_valid;
    assign bus.pair_pixels_o  = r_pair_pixels;
    assign bus.pair_sof_o     = r_pair_sof;
    assign bus.pair_eol_o     = r_pair_eol;
    assign bus.pair_eof_o     = r_pair_eof;
    assign bus.aligned_o      = (r_state == S_STREAM);
    assign bus.resync_count_o = r_resync;

endmodule
